// File: rtl/memory_ctrl_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
package memory_ctrl_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_RD_LAT = 2;

  // Read-latency counter width; covers the legal RD_LAT range 1..7.
  localparam int RD_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Requester index: 0 = port 0, 1 = port 1.
  typedef logic port_idx_t;

  localparam port_idx_t PORT0 = 1'b0;
  localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic. Purely combinational; the caller owns the
// last_grant register and decides when arbitration is allowed via enable.
module rr_arbiter2
  import memory_ctrl_pkg::*;
(
  input  logic      [1:0] req,
  input  port_idx_t       last_grant,
  input  logic            enable,
  output logic      [1:0] grant,
  output port_idx_t       gnt_idx
);

  // Pick the single requester, or on a tie the port that did not win last.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant   = 2'b00;
    gnt_idx = PORT0;
    if (enable) begin
      case (req)
        2'b01: begin
          grant   = 2'b01;
          gnt_idx = PORT0;
        end
        2'b10: begin
          grant   = 2'b10;
          gnt_idx = PORT1;
        end
        2'b11: begin
          if (last_grant == PORT0) begin
            grant   = 2'b10;
            gnt_idx = PORT1;
          end else begin
            grant   = 2'b01;
            gnt_idx = PORT0;
          end
        end
        default: begin
          grant   = 2'b00;
          gnt_idx = PORT0;
        end
      endcase
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port controller sharing one single-ported memory block. Requests are
// arbitrated round-robin; each transaction is sequenced through WRITE or READ
// and finished with a one-cycle ack in DONE. All outputs are registered.
module memory_arbiter
  import memory_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT   // legal range 1..7
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,

  output logic              mem_write,
  output logic              mem_read,
  output logic              mem_activate,
  output logic [ADDR_W-1:0] mem_addrin,
  output logic [ADDR_W-1:0] mem_addrout,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,

  output logic              busy
);

  // Last rd_cnt value of a read: the cycle in which mem_dataout is valid.
  localparam logic [RD_CNT_W-1:0] RD_LAST = RD_CNT_W'(RD_LAT - 1);

  state_t                state;
  port_idx_t             last_grant;
  port_idx_t             gnt_q;
  logic [RD_CNT_W-1:0]   rd_cnt;

  logic                  arb_en;
  logic [1:0]            grant;
  port_idx_t             gnt_idx;

  logic                  sel_we;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;

  assign arb_en = (state == IDLE);

  rr_arbiter2 u_arb (
    .req        ({req1, req0}),
    .last_grant (last_grant),
    .enable     (arb_en),
    .grant      (grant),
    .gnt_idx    (gnt_idx)
  );

  // Route the winning port's command fields toward the latching registers.
  assign sel_we    = (gnt_idx == PORT1) ? we1    : we0;
  assign sel_addr  = (gnt_idx == PORT1) ? addr1  : addr0;
  assign sel_wdata = (gnt_idx == PORT1) ? wdata1 : wdata0;

  // Transaction FSM. The mem_* address/data registers double as the latched
  // command: they are loaded on grant and cleared when the active state ends,
  // so no stale address is ever presented to the memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every register, including the rdata holding registers, is reset so all outputs read 0.
      state        <= IDLE;
      last_grant   <= PORT1;
      gnt_q        <= PORT0;
      rd_cnt       <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      mem_write    <= 1'b0;
      mem_read     <= 1'b0;
      mem_activate <= 1'b0;
      mem_addrin   <= '0;
      mem_addrout  <= '0;
      mem_datain   <= '0;
      busy         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      case (state)
        IDLE: begin
          if (|grant) begin
            gnt_q        <= gnt_idx;
            last_grant   <= gnt_idx;
            busy         <= 1'b1;
            mem_activate <= 1'b1;
            if (sel_we) begin
              state      <= WRITE;
              mem_write  <= 1'b1;
              mem_addrin <= sel_addr;
              mem_datain <= sel_wdata;
            end else begin
              state       <= READ;
              mem_read    <= 1'b1;
              mem_addrout <= sel_addr;
              rd_cnt      <= '0;
            end
          end
        end

        WRITE: begin
          state        <= DONE;
          mem_write    <= 1'b0;
          mem_activate <= 1'b0;
          mem_addrin   <= '0;
          mem_datain   <= '0;
          ack0         <= (gnt_q == PORT0);
          ack1         <= (gnt_q == PORT1);
        end

        READ: begin
          if (rd_cnt == RD_LAST) begin
            state        <= DONE;
            rd_cnt       <= '0;
            mem_read     <= 1'b0;
            mem_activate <= 1'b0;
            mem_addrout  <= '0;
            ack0         <= (gnt_q == PORT0);
            ack1         <= (gnt_q == PORT1);
            // Only the granted port's holding register changes.
            if (gnt_q == PORT1) begin
              rdata1 <= mem_dataout;
            end else begin
              rdata0 <= mem_dataout;
            end
          end else begin
            rd_cnt <= rd_cnt + RD_CNT_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
